csr_ctrl: RTL and testbench
===========================

Name: csr_ctrl

Overview:
- Sequences Zicsr instructions (CSRRW/RS/RC and the immediate forms) from the execute stage against the CSR file (`csr`).
- Each access is a read-modify-write: read the old value, compute the new value, conditionally write, then return the old value.
- Detects illegal accesses: unimplemented CSR addresses, writes to read-only CSRs, and reserved funct3 encodings.
- Sits between the decoder/execute stage and the CSR file. It is the only driver of the CSR file's wen, addr and wdata.

Parameters:
- XLEN, 32, CSR/register data width; must match the CSR file word width.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  CSR instruction presented
- req_ready  output  1  controller can accept a request
- req_funct3  input  3  Zicsr funct3 (001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI)
- req_addr  input  12  CSR address
- req_rs1_idx  input  5  rs1 field; doubles as zimm for the immediate forms
- req_rs1_data  input  XLEN  rs1 register value
- resp_valid  output  1  result available
- resp_ready  input  1  consumer accepts result
- resp_rdata  output  XLEN  old CSR value (destined for rd)
- resp_illegal  output  1  illegal-instruction flag for this access
- csr_wen  output  1  write enable to CSR file
- csr_addr  output  12  address to CSR file
- csr_wdata  output  XLEN  write data to CSR file
- csr_rdata  input  XLEN  combinational read data from CSR file

Behaviour:
- One clock; reset is synchronous and active-high.
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch funct3, addr, rs1_idx and rs1_data, then go to READ.
- READ:
  - csr_addr=latched addr.
  - Capture csr_rdata into old_q.
  - Compute new_q and illegal_q.
  - Go to WRITE.
- WRITE:
  - csr_addr=latched addr, csr_wdata=new_q.
  - csr_wen=1 only if write_intent is true and illegal_q is false. It is asserted for exactly this one cycle.
  - Go to RESP.
- RESP:
  - resp_valid=1, resp_rdata=old_q, resp_illegal=illegal_q.
  - Outputs are held stable until resp_ready; on resp_ready go to IDLE.
  - A new request is accepted no earlier than the cycle after the handshake.
- Latency: request accepted at edge T; READ T+1; WRITE T+2; resp_valid asserted from T+3. No back-to-back overlap.
- Operand: src = rs1_data for funct3[2]=0; src = zero-extended rs1_idx (zimm) for funct3[2]=1.
- New value:
  - RW/RWI: new = src.
  - RS/RSI: new = old | src.
  - RC/RCI: new = old & ~src.
- write_intent:
  - RW/RWI: always 1.
  - RS/RC/RSI/RCI: 1 only if rs1_idx != 0. An x0 or zimm=0 source never writes and is never illegal on read-only CSRs.
- illegal is true if any of the following holds:
  - funct3 is 000 or 100;
  - addr is not one of 12'h301 (misa), 12'hF11 (mvendorid), 12'hF12 (marchid), 12'hB00 (cycle low), 12'hB80 (cycle high);
  - write_intent is 1 and addr[11:10]==2'b11 (read-only space).
- For illegal accesses: no write, resp_rdata=0.
- misa is WARL: writes are legal and are issued to the CSR file, which ignores them.
- The cycle counter keeps running: resp_rdata is the value sampled in READ. A write to cycle lands at the end of WRITE and the counter resumes from the written value.
- Idle outputs: csr_addr=0 in IDLE and RESP; csr_wen=0 outside WRITE.
- Reset values: req_ready=0 during reset, then 1 in IDLE. resp_valid=0, resp_rdata=0, resp_illegal=0, csr_wen=0, csr_addr=0, csr_wdata=0.
- Reset mid-operation: the FSM returns to IDLE on the reset edge. An in-flight write in WRITE is not issued if reset is high in that cycle, and no response is produced.

Decomposition:
- csr_pkg holds:
  - CSR address constants (MISA, MVENDORID, MARCHID, CYCLE, CYCLEH);
  - the funct3 enum (CSRRW..CSRRCI);
  - the state enum (IDLE/READ/WRITE/RESP).
- One combinational sub-module, csr_rmw, computes new value, write_intent and illegal from funct3, rs1_idx, rs1_data, old value and addr.
- The FSM and registers live in csr_ctrl.

Test Plan:
- CSRRS, addr F11, rs1_idx=0 -> resp_rdata=32'h616b6562, resp_illegal=0, csr_wen never asserted, resp_valid 3 cycles after accept.
- CSRRW, addr B00, rs1_data=32'h0000_1000 -> csr_wen pulses once with wdata 32'h1000; a following CSRRS of B00 with x0 returns ≥ 32'h1000 and < 32'h1010.
- CSRRWI, addr F12, zimm=5 -> resp_illegal=1, resp_rdata=0, no csr_wen, marchid unchanged on a subsequent read (32'h05318008).
- CSRRC, addr 301, rs1_data=32'h0000_0010 -> rdata=32'h4000_0010, csr_wdata=32'h4000_0000 with wen=1; next read still 32'h4000_0010.
- funct3=100 or addr 12'h340 -> resp_illegal=1, no write. Hold resp_ready=0 for 4 cycles -> resp_valid and resp data stay stable and req_ready stays 0.
- Assert reset during WRITE -> csr_wen=0 that cycle, resp_valid never rises, req_ready=1 the cycle after reset deasserts.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared definitions for the Zicsr access controller: implemented CSR addresses,
// funct3 encodings and controller states.
package csr_pkg;

  localparam logic [11:0] MISA      = 12'h301;
  localparam logic [11:0] MVENDORID = 12'hF11;
  localparam logic [11:0] MARCHID   = 12'hF12;
  localparam logic [11:0] CYCLE     = 12'hB00;
  localparam logic [11:0] CYCLEH    = 12'hB80;

  typedef enum logic [2:0] {
    CSRRW  = 3'b001,
    CSRRS  = 3'b010,
    CSRRC  = 3'b011,
    CSRRWI = 3'b101,
    CSRRSI = 3'b110,
    CSRRCI = 3'b111
  } csr_funct3_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } csr_state_e;

  function automatic logic csr_implemented(input logic [11:0] addr);
    return (addr == MISA) || (addr == MVENDORID) || (addr == MARCHID) ||
           (addr == CYCLE) || (addr == CYCLEH);
  endfunction

endpackage

// File: rtl/csr_rmw.sv
// Combinational read-modify-write datapath: new CSR value, whether the
// instruction intends to write, and whether the access is illegal.
module csr_rmw
  import csr_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3_i,
  input  logic [11:0]     addr_i,
  input  logic [4:0]      rs1_idx_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] old_i,
  output logic [XLEN-1:0] new_o,
  output logic            write_intent_o,
  output logic            illegal_o
);

  logic [XLEN-1:0] src;
  logic            reserved;

  // Immediate forms use the rs1 field itself as a zero-extended operand.
  assign src = funct3_i[2] ? {{(XLEN-5){1'b0}}, rs1_idx_i} : rs1_data_i;

  always_comb begin
    new_o          = src;
    write_intent_o = 1'b0;
    reserved       = 1'b0;
    case (funct3_i)
      CSRRW, CSRRWI: begin
        new_o          = src;
        write_intent_o = 1'b1;
      end
      CSRRS, CSRRSI: begin
        new_o          = old_i | src;
        write_intent_o = (rs1_idx_i != 5'd0);
      end
      CSRRC, CSRRCI: begin
        new_o          = old_i & ~src;
        write_intent_o = (rs1_idx_i != 5'd0);
      end
      default: reserved = 1'b1;
    endcase
  end

  // Top two address bits set marks the read-only CSR space.
  assign illegal_o = reserved || !csr_implemented(addr_i) ||
                     (write_intent_o && (addr_i[11:10] == 2'b11));

endmodule

// File: rtl/csr_ctrl.sv
// Sequences one Zicsr instruction at a time through READ, WRITE and RESP
// against a CSR file with combinational read data.
module csr_ctrl
  import csr_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_funct3,
  input  logic [11:0]     req_addr,
  input  logic [4:0]      req_rs1_idx,
  input  logic [XLEN-1:0] req_rs1_data,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_illegal,
  output logic            csr_wen,
  output logic [11:0]     csr_addr,
  output logic [XLEN-1:0] csr_wdata,
  input  logic [XLEN-1:0] csr_rdata
);

  csr_state_e      state_q, state_d;
  logic [2:0]      funct3_q;
  logic [11:0]     addr_q;
  logic [4:0]      rs1_idx_q;
  logic [XLEN-1:0] rs1_data_q;
  logic [XLEN-1:0] old_q;
  logic [XLEN-1:0] new_q;
  logic            illegal_q;
  logic            intent_q;

  logic [XLEN-1:0] rmw_new;
  logic            rmw_intent;
  logic            rmw_illegal;

  // Old value comes straight from the CSR file while csr_addr presents addr_q in READ.
  csr_rmw #(.XLEN(XLEN)) u_rmw (
    .funct3_i       (funct3_q),
    .addr_i         (addr_q),
    .rs1_idx_i      (rs1_idx_q),
    .rs1_data_i     (rs1_data_q),
    .old_i          (csr_rdata),
    .new_o          (rmw_new),
    .write_intent_o (rmw_intent),
    .illegal_o      (rmw_illegal)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      funct3_q   <= '0;
      addr_q     <= '0;
      rs1_idx_q  <= '0;
      rs1_data_q <= '0;
      old_q      <= '0;
      new_q      <= '0;
      illegal_q  <= 1'b0;
      intent_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && req_valid) begin
        funct3_q   <= req_funct3;
        addr_q     <= req_addr;
        rs1_idx_q  <= req_rs1_idx;
        rs1_data_q <= req_rs1_data;
      end
      if (state_q == READ) begin
        // Illegal accesses report zero rather than leaking the CSR contents.
        old_q     <= rmw_illegal ? '0 : csr_rdata;
        new_q     <= rmw_new;
        illegal_q <= rmw_illegal;
        intent_q  <= rmw_intent;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    resp_rdata   = '0;
    resp_illegal = 1'b0;
    csr_wen      = 1'b0;
    csr_addr     = '0;
    csr_wdata    = '0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = READ;
      end
      READ: begin
        csr_addr = addr_q;
        state_d  = WRITE;
      end
      WRITE: begin
        csr_addr  = addr_q;
        csr_wdata = new_q;
        csr_wen   = intent_q && !illegal_q;
        state_d   = RESP;
      end
      RESP: begin
        resp_valid   = 1'b1;
        resp_rdata   = old_q;
        resp_illegal = illegal_q;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset suppresses every output in the same cycle, including an in-flight write.
    if (reset) begin
      req_ready    = 1'b0;
      resp_valid   = 1'b0;
      resp_rdata   = '0;
      resp_illegal = 1'b0;
      csr_wen      = 1'b0;
      csr_addr     = '0;
      csr_wdata    = '0;
    end
  end

endmodule

// File: tb/tb_csr_ctrl.sv
// Scoreboard bench for csr_ctrl with a small behavioural CSR file
// (constant ID registers, ignored misa writes, running 64-bit cycle counter).
module tb_csr_ctrl;

  localparam int XLEN = 32;

  logic            clock = 1'b0;
  logic            reset;
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_funct3;
  logic [11:0]     req_addr;
  logic [4:0]      req_rs1_idx;
  logic [XLEN-1:0] req_rs1_data;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_illegal;
  logic            csr_wen;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] csr_wdata;
  logic [XLEN-1:0] csr_rdata;

  always #5 clock = ~clock;

  csr_ctrl #(.XLEN(XLEN)) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_rs1_idx  (req_rs1_idx),
    .req_rs1_data (req_rs1_data),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_illegal (resp_illegal),
    .csr_wen      (csr_wen),
    .csr_addr     (csr_addr),
    .csr_wdata    (csr_wdata),
    .csr_rdata    (csr_rdata)
  );

  // CSR file model
  logic [63:0] cycle_q;
  always @(posedge clock) begin
    if (reset)                                 cycle_q <= 64'd0;
    else if (csr_wen && csr_addr == 12'hB00)   cycle_q <= {cycle_q[63:32], csr_wdata};
    else if (csr_wen && csr_addr == 12'hB80)   cycle_q <= {csr_wdata, cycle_q[31:0]};
    else                                       cycle_q <= cycle_q + 64'd1;
  end

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      12'h301: csr_rdata = 32'h4000_0010;
      12'hF11: csr_rdata = 32'h616b_6562;
      12'hF12: csr_rdata = 32'h0531_8008;
      12'hB00: csr_rdata = cycle_q[31:0];
      12'hB80: csr_rdata = cycle_q[63:32];
      default: csr_rdata = '0;
    endcase
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int          id;
    bit          chk_rd;
    logic [31:0] lo;
    logic [31:0] hi;
    bit          ill;
    int          wen_total;
    bit          wen;
    logic [31:0] wdata;
    logic [11:0] waddr;
  } exp_t;

  exp_t        sb[$];
  exp_t        e_m;
  int          txn_id = 0;
  int          wen_cnt = 0;
  logic [31:0] last_wdata = '0;
  logic [11:0] last_waddr = '0;

  always @(negedge clock) begin
    if (csr_wen) begin
      wen_cnt++;
      last_wdata = csr_wdata;
      last_waddr = csr_addr;
    end
  end

  // Pop and compare on the cycle the response handshake completes.
  always @(negedge clock) begin
    if (resp_valid && resp_ready) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", sb.size(), 1);
      end else begin
        e_m = sb.pop_front();
        chk("illegal", resp_illegal, e_m.ill);
        if (e_m.chk_rd) begin
          if (e_m.lo == e_m.hi) chk("rdata", resp_rdata, e_m.lo);
          else begin
            chk("rdata_ge", resp_rdata >= e_m.lo, 1);
            chk("rdata_lt", resp_rdata < e_m.hi, 1);
          end
        end
        chk("wen_count", wen_cnt, e_m.wen_total);
        if (e_m.wen) begin
          chk("wdata", last_wdata, e_m.wdata);
          chk("waddr", last_waddr, e_m.waddr);
        end
        $display("txn %0d: rdata=%08h illegal=%0b writes=%0d", e_m.id, resp_rdata, resp_illegal, wen_cnt);
      end
    end
  end

  task automatic issue(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] idx,
                       input logic [31:0] d, input bit chk_rd, input logic [31:0] lo,
                       input logic [31:0] hi, input bit ill, input bit wen,
                       input logic [31:0] wd, input int hold);
    int          k;
    exp_t        e;
    logic [31:0] rd0;
    logic        il0;
    k = 0;
    @(negedge clock);
    while (!req_ready && k < 20) begin
      @(negedge clock);
      k++;
    end
    if (!req_ready) begin
      chk("req_ready_wait", req_ready, 1);
      return;
    end
    req_valid    = 1'b1;
    req_funct3   = f3;
    req_addr     = a;
    req_rs1_idx  = idx;
    req_rs1_data = d;
    e.id        = txn_id++;
    e.chk_rd    = chk_rd;
    e.lo        = lo;
    e.hi        = hi;
    e.ill       = ill;
    e.wen_total = wen_cnt + (wen ? 1 : 0);
    e.wen       = wen;
    e.wdata     = wd;
    e.waddr     = a;
    sb.push_back(e);
    @(posedge clock);
    #1 req_valid = 1'b0;
    k = 0;
    do begin
      @(negedge clock);
      k++;
    end while (!resp_valid && k < 10);
    chk("latency", k, 3);
    if (!resp_valid) return;
    rd0 = resp_rdata;
    il0 = resp_illegal;
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      chk("hold_valid", resp_valid, 1);
      chk("hold_rdata", resp_rdata, rd0);
      chk("hold_illegal", resp_illegal, il0);
      chk("hold_req_ready", req_ready, 0);
    end
    @(posedge clock);
    #1 resp_ready = 1'b1;
    @(posedge clock);
    #1 resp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int  w0;
    bit  any_v;
    reset = 1'b1; req_valid = 1'b0; req_funct3 = '0; req_addr = '0;
    req_rs1_idx = '0; req_rs1_data = '0; resp_ready = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_csr_wen", csr_wen, 0);
    chk("rst_csr_addr", csr_addr, 0);
    chk("rst_csr_wdata", csr_wdata, 0);
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("idle_req_ready", req_ready, 1);

    //     f3      addr     idx    data          chk lo             hi             ill wen wdata         hold
    issue(3'b010, 12'hF11, 5'd0,  32'hdeadbeef, 1, 32'h616b6562, 32'h616b6562, 0, 0, 32'h0,        0);
    issue(3'b001, 12'hB00, 5'd7,  32'h00001000, 0, 32'h0,        32'h0,        0, 1, 32'h00001000, 0);
    issue(3'b010, 12'hB00, 5'd0,  32'h0,        1, 32'h00001000, 32'h00001010, 0, 0, 32'h0,        0);
    issue(3'b101, 12'hF12, 5'd5,  32'h0,        1, 32'h0,        32'h0,        1, 0, 32'h0,        0);
    issue(3'b010, 12'hF12, 5'd0,  32'h0,        1, 32'h05318008, 32'h05318008, 0, 0, 32'h0,        0);
    issue(3'b011, 12'h301, 5'd2,  32'h00000010, 1, 32'h40000010, 32'h40000010, 0, 1, 32'h40000000, 0);
    issue(3'b010, 12'h301, 5'd0,  32'hffffffff, 1, 32'h40000010, 32'h40000010, 0, 0, 32'h0,        0);
    issue(3'b100, 12'h301, 5'd1,  32'h0,        1, 32'h0,        32'h0,        1, 0, 32'h0,        4);
    issue(3'b001, 12'h340, 5'd1,  32'h5,        1, 32'h0,        32'h0,        1, 0, 32'h0,        0);
    issue(3'b110, 12'hF11, 5'd0,  32'h0,        1, 32'h616b6562, 32'h616b6562, 0, 0, 32'h0,        0);
    issue(3'b010, 12'hF11, 5'd3,  32'h1,        1, 32'h0,        32'h0,        1, 0, 32'h0,        0);
    issue(3'b000, 12'hB00, 5'd1,  32'h1,        1, 32'h0,        32'h0,        1, 0, 32'h0,        2);
    issue(3'b111, 12'h301, 5'h10, 32'h0,        1, 32'h40000010, 32'h40000010, 0, 1, 32'h40000000, 0);
    issue(3'b110, 12'hB80, 5'd3,  32'h0,        1, 32'h0,        32'h0,        0, 1, 32'h00000003, 0);
    issue(3'b010, 12'hB80, 5'd0,  32'h0,        1, 32'h3,        32'h3,        0, 0, 32'h0,        0);

    // Reset while the controller sits in WRITE with a pending legal write.
    @(negedge clock);
    chk("rstw_ready", req_ready, 1);
    req_valid = 1'b1; req_funct3 = 3'b001; req_addr = 12'hB00;
    req_rs1_idx = 5'd1; req_rs1_data = 32'h1234;
    w0 = wen_cnt;
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    chk("rstw_csr_wen", csr_wen, 0);
    chk("rstw_req_ready", req_ready, 0);
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rstw_release_ready", req_ready, 1);
    any_v = 1'b0;
    repeat (6) begin
      @(negedge clock);
      if (resp_valid) any_v = 1'b1;
    end
    chk("rstw_no_resp", any_v, 0);
    chk("rstw_no_write", wen_cnt, w0);
    chk("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
